serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 115 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // One spare bit so W=1 and power-of-two widths never wrap before the last bit.
    function automatic int unsigned cnt_width(int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell reused by the serial adder controller.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);

    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder: one full_adder cell reused LSB-first, one bit per clock,
// with a start/done handshake and registered sum/carry outputs.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] S,
    output logic         Co
);

    localparam int unsigned     CntW    = cnt_width(W);
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    s_sh_q, s_sh_d;
    logic [W-1:0]    s_q, s_d;
    logic            carry_q, carry_d;
    logic            co_q, co_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            fa_s;
    logic            fa_co;
    logic [W-1:0]    s_next;

    full_adder u_fa (
        .A  (a_sh_q[0]),
        .B  (b_sh_q[0]),
        .Ci (carry_q),
        .S  (fa_s),
        .Co (fa_co)
    );

    // New sum bit enters at the MSB; written as shifts so W=1 needs no special case.
    assign s_next = (s_sh_q >> 1) | (W'(fa_s) << (W - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    carry_d = Ci;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                carry_d = fa_co;
                s_sh_d  = s_next;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    s_d     = s_next;
                    co_d    = fa_co;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign S    = s_q;
    assign Co   = co_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at W=4, W=1 and W=8.
module tb_serial_adder_ctrl;

    typedef struct {
        logic [8:0]  res;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          mon_en  = 1'b0;

    logic       rst;
    logic       start4, ci4, busy4, done4, co4;
    logic [3:0] a4, b4, s4;
    logic       start1, ci1, busy1, done1, co1;
    logic [0:0] a1, b1, s1;
    logic       start8, ci8, busy8, done8, co8;
    logic [7:0] a8, b8, s8;

    exp_t       q4[$];
    exp_t       q1[$];
    exp_t       q8[$];
    logic [4:0] hold4;

    serial_adder_ctrl #(.W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Ci(ci4),
        .busy(busy4), .done(done4), .S(s4), .Co(co4)
    );
    serial_adder_ctrl #(.W(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Ci(ci1),
        .busy(busy1), .done(done1), .S(s1), .Co(co1)
    );
    serial_adder_ctrl #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Ci(ci8),
        .busy(busy8), .done(done8), .S(s8), .Co(co8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic unexpected_done(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: done pulse with no pending add (cycle %0d)", name, cyc);
    endtask

    // Monitors: results are expected to be exactly A+B+Ci, W cycles after the accept edge.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (mon_en) begin
            if (done4) begin
                if (q4.size() == 0) unexpected_done("w4_done");
                else begin
                    e = q4.pop_front();
                    check("w4_result", {27'd0, co4, s4}, {23'd0, e.res});
                    check("w4_latency", cyc - e.cyc, 32'd4);
                    check("w4_busy_in_done", {31'd0, busy4}, 32'd0);
                    hold4 = e.res[4:0];
                end
            end else begin
                check("w4_hold", {27'd0, co4, s4}, {27'd0, hold4});
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (mon_en && done1) begin
            if (q1.size() == 0) unexpected_done("w1_done");
            else begin
                e = q1.pop_front();
                check("w1_result", {30'd0, co1, s1}, {23'd0, e.res});
                check("w1_latency", cyc - e.cyc, 32'd1);
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (mon_en && done8) begin
            if (q8.size() == 0) unexpected_done("w8_done");
            else begin
                e = q8.pop_front();
                check("w8_result", {23'd0, co8, s8}, {23'd0, e.res});
                check("w8_latency", cyc - e.cyc, 32'd8);
            end
        end
    end

    // One W=4 add; with noise, start and operands toggle randomly while the add is in flight.
    task automatic do_add4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                           input bit noise);
        a4 = a; b4 = b; ci4 = ci; start4 = 1'b1;
        @(posedge clk); #1;
        q4.push_back('{res: 9'(a) + 9'(b) + 9'(ci), cyc: cyc});
        for (int i = 0; i <= 4; i++) begin
            check("w4_busy", {31'd0, busy4}, {31'd0, (i < 4)});
            start4 = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            a4     = 4'($urandom);
            b4     = 4'($urandom);
            ci4    = 1'($urandom);
            @(posedge clk); #1;
        end
        start4 = 1'b0;
    endtask

    task automatic do_add1(input logic a, input logic b, input logic ci);
        a1 = a; b1 = b; ci1 = ci; start1 = 1'b1;
        @(posedge clk); #1;
        q1.push_back('{res: 9'(a) + 9'(b) + 9'(ci), cyc: cyc});
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
        @(posedge clk); #1;
        q8.push_back('{res: 9'(a) + 9'(b) + 9'(ci), cyc: cyc});
        start8 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned e0;
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        hold4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy4", {31'd0, busy4}, 32'd0);
        check("rst_done4", {31'd0, done4}, 32'd0);
        check("rst_sum4", {27'd0, co4, s4}, 32'd0);
        check("rst_busy1", {31'd0, busy1}, 32'd0);
        check("rst_sum8", {23'd0, co8, s8}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        do_add4(4'h5, 4'h3, 1'b0, 1'b0);
        do_add4(4'hF, 4'h1, 1'b0, 1'b0);
        do_add4(4'hF, 4'hF, 1'b1, 1'b0);

        // start held 10 edges; operands change after the first accept.
        a4 = 4'h5; b4 = 4'h3; ci4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        q4.push_back('{res: 9'h008, cyc: e0});
        q4.push_back('{res: 9'h014, cyc: e0 + 6});
        a4 = 4'hA; b4 = 4'hA;
        repeat (9) @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the second SHIFT cycle aborts the add without a done pulse.
        a4 = 4'h7; b4 = 4'h7; ci4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        hold4 = '0;
        check("abort_busy", {31'd0, busy4}, 32'd0);
        check("abort_done", {31'd0, done4}, 32'd0);
        check("abort_sum", {27'd0, co4, s4}, 32'd0);
        do_add4(4'h1, 4'h1, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            do_add1(1'(i >> 2), 1'(i >> 1), 1'(i));
        end

        do_add8(8'hFF, 8'h01, 1'b1);
        repeat (4) do_add8(8'($urandom), 8'($urandom), 1'($urandom));

        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_add4(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
        end

        for (int k = 0; k < 50 && (q4.size() + q1.size() + q8.size()) != 0; k++) begin
            @(posedge clk);
        end
        #1;
        check("w4_pending", q4.size(), 32'd0);
        check("w1_pending", q1.size(), 32'd0);
        check("w8_pending", q8.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
